// File: rtl/ctrl_packet_injector_if.sv
// Bundles the forward, return, command and response signals of the control packet injector.
// slave = injector side, master = host/chain side driving the injector inputs.
interface ctrl_packet_injector_if #(
  parameter int DATA_WIDTH     = 512,
  parameter int STREAM_ID_NUM  = 16,
  parameter int CHUNK_ID_NUM   = 32,
  parameter int CHANNEL_ID_NUM = 1024,
  parameter int STATE_WIDTH    = 32
);
  localparam int STREAM_ID_WIDTH  = $clog2(STREAM_ID_NUM);
  localparam int CHUNK_ID_WIDTH   = $clog2(CHUNK_ID_NUM);
  localparam int CHANNEL_ID_WIDTH = $clog2(CHANNEL_ID_NUM);

  logic [DATA_WIDTH-1:0]       in_Data;
  logic [1:0]                  in_Type;
  logic                        in_Last;
  logic [STREAM_ID_WIDTH-1:0]  in_StreamID;
  logic [CHUNK_ID_WIDTH-1:0]   in_ChunkID;
  logic [CHANNEL_ID_WIDTH-1:0] in_ChannelID;
  logic [STATE_WIDTH-1:0]      in_State;

  logic [DATA_WIDTH-1:0]       out_Data;
  logic [1:0]                  out_Type;
  logic                        out_Last;
  logic [STREAM_ID_WIDTH-1:0]  out_StreamID;
  logic [CHUNK_ID_WIDTH-1:0]   out_ChunkID;
  logic [CHANNEL_ID_WIDTH-1:0] out_ChannelID;
  logic [STATE_WIDTH-1:0]      out_State;

  logic [DATA_WIDTH-1:0]       ret_Data;
  logic [1:0]                  ret_Type;
  logic [CHUNK_ID_WIDTH-1:0]   ret_ChunkID;
  logic [STATE_WIDTH-1:0]      ret_State;

  logic                        cmd_valid;
  logic                        cmd_ready;
  logic                        cmd_write;
  logic [CHANNEL_ID_WIDTH-1:0] cmd_hop;
  logic [STATE_WIDTH-1:0]      cmd_addr;
  logic [31:0]                 cmd_wdata;

  logic                        resp_valid;
  logic [31:0]                 resp_rdata;
  logic                        resp_timeout;
  logic                        busy;

  modport slave (
    input  in_Data, in_Type, in_Last, in_StreamID, in_ChunkID, in_ChannelID, in_State,
    output out_Data, out_Type, out_Last, out_StreamID, out_ChunkID, out_ChannelID, out_State,
    input  ret_Data, ret_Type, ret_ChunkID, ret_State,
    input  cmd_valid, cmd_write, cmd_hop, cmd_addr, cmd_wdata,
    output cmd_ready, resp_valid, resp_rdata, resp_timeout, busy
  );

  modport master (
    output in_Data, in_Type, in_Last, in_StreamID, in_ChunkID, in_ChannelID, in_State,
    input  out_Data, out_Type, out_Last, out_StreamID, out_ChunkID, out_ChannelID, out_State,
    output ret_Data, ret_Type, ret_ChunkID, ret_State,
    output cmd_valid, cmd_write, cmd_hop, cmd_addr, cmd_wdata,
    input  cmd_ready, resp_valid, resp_rdata, resp_timeout, busy
  );
endinterface

// File: rtl/ctrl_packet_injector.sv
// Forwards the upstream stream with 1-cycle latency and slips relative control writes/reads into idle gaps.
// Upstream is never stalled: commands wait in PENDING (cmd_ready=0) for a gap; reads then await a response or timeout.
module ctrl_packet_injector #(
  parameter int DATA_WIDTH                  = 512,
  parameter int STREAM_ID_NUM               = 16,
  parameter int CHUNK_ID_NUM                = 32,
  parameter int CHANNEL_ID_NUM              = 1024,
  parameter int STATE_WIDTH                 = 32,
  parameter int TIMEOUT_CYCLES              = 1024,
  parameter int CP_R_CTRL_READ_REQUEST_32b  = 0,
  parameter int CP_R_CTRL_WRITE_32b         = 1,
  parameter int CP_A_CTRL_READ_RESPONSE_32b = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  ctrl_packet_injector_if.slave bus
);
  localparam int STREAM_ID_WIDTH  = $clog2(STREAM_ID_NUM);
  localparam int CHUNK_ID_WIDTH   = $clog2(CHUNK_ID_NUM);
  localparam int CHANNEL_ID_WIDTH = $clog2(CHANNEL_ID_NUM);
  localparam int OPCODE_WIDTH     = CHUNK_ID_WIDTH - 1;
  localparam int TIMER_WIDTH      = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_PENDING, S_WAIT_RESP} state_t;

  state_t                      r_state;
  state_t                      w_state_nxt;
  logic                        r_pkt_open;
  logic                        r_cmd_write;
  logic [CHANNEL_ID_WIDTH-1:0] r_cmd_hop;
  logic [STATE_WIDTH-1:0]      r_cmd_addr;
  logic [31:0]                 r_cmd_wdata;
  logic [TIMER_WIDTH-1:0]      r_timer;

  logic [DATA_WIDTH-1:0]       r_out_data;
  logic [1:0]                  r_out_type;
  logic                        r_out_last;
  logic [STREAM_ID_WIDTH-1:0]  r_out_stream;
  logic [CHUNK_ID_WIDTH-1:0]   r_out_chunk;
  logic [CHANNEL_ID_WIDTH-1:0] r_out_channel;
  logic [STATE_WIDTH-1:0]      r_out_state;
  logic                        r_resp_valid;
  logic [31:0]                 r_resp_rdata;
  logic                        r_resp_timeout;

  logic w_gap, w_match, w_latch, w_inject, w_resp, w_timeout;
  logic w_unused;

  assign w_gap   = (bus.in_Type == 2'b00) && !r_pkt_open;
  assign w_match = bus.ret_Type[1] && !bus.ret_ChunkID[CHUNK_ID_WIDTH-1]
                && (bus.ret_ChunkID[OPCODE_WIDTH-1:0] == OPCODE_WIDTH'(CP_A_CTRL_READ_RESPONSE_32b))
                && (bus.ret_State == r_cmd_addr);
  assign w_unused = ^{bus.ret_Type[0], bus.ret_Data[DATA_WIDTH-1:32]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_inject    = 1'b0;
    w_resp      = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          w_latch     = 1'b1;
          w_state_nxt = S_PENDING;
        end
      end
      S_PENDING: begin
        if (w_gap) begin
          w_inject    = 1'b1;
          w_state_nxt = r_cmd_write ? S_IDLE : S_WAIT_RESP;
        end
      end
      S_WAIT_RESP: begin
        // A response landing on the last timer cycle still counts as a hit.
        if (w_match) begin
          w_resp      = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (r_timer == TIMER_WIDTH'(TIMEOUT_CYCLES - 1)) begin
          w_resp      = 1'b1;
          w_timeout   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pkt_open     <= 1'b0;
      r_cmd_write    <= 1'b0;
      r_cmd_hop      <= '0;
      r_cmd_addr     <= '0;
      r_cmd_wdata    <= '0;
      r_timer        <= '0;
      r_out_data     <= '0;
      r_out_type     <= '0;
      r_out_last     <= 1'b0;
      r_out_stream   <= '0;
      r_out_chunk    <= '0;
      r_out_channel  <= '0;
      r_out_state    <= '0;
      r_resp_valid   <= 1'b0;
      r_resp_rdata   <= '0;
      r_resp_timeout <= 1'b0;
    end else begin
      if (bus.in_Type != 2'b00) r_pkt_open <= !bus.in_Last;
      if (w_latch) begin
        r_cmd_write <= bus.cmd_write;
        r_cmd_hop   <= bus.cmd_hop;
        r_cmd_addr  <= bus.cmd_addr;
        r_cmd_wdata <= bus.cmd_wdata;
      end
      if (w_inject) begin
        r_out_data    <= r_cmd_write ? {(DATA_WIDTH/32){r_cmd_wdata}} : '0;
        r_out_type    <= 2'b10;
        r_out_last    <= 1'b1;
        r_out_stream  <= '0;
        r_out_chunk   <= {1'b1, r_cmd_write ? OPCODE_WIDTH'(CP_R_CTRL_WRITE_32b)
                                            : OPCODE_WIDTH'(CP_R_CTRL_READ_REQUEST_32b)};
        r_out_channel <= r_cmd_hop;
        r_out_state   <= r_cmd_addr;
      end else begin
        r_out_data    <= bus.in_Data;
        r_out_type    <= bus.in_Type;
        r_out_last    <= bus.in_Last;
        r_out_stream  <= bus.in_StreamID;
        r_out_chunk   <= bus.in_ChunkID;
        r_out_channel <= bus.in_ChannelID;
        r_out_state   <= bus.in_State;
      end
      r_timer      <= (r_state == S_WAIT_RESP) ? r_timer + TIMER_WIDTH'(1) : '0;
      r_resp_valid <= w_resp;
      if (w_resp) begin
        r_resp_rdata   <= w_timeout ? 32'd0 : bus.ret_Data[31:0];
        r_resp_timeout <= w_timeout;
      end
    end
  end

  assign bus.out_Data      = r_out_data;
  assign bus.out_Type      = r_out_type;
  assign bus.out_Last      = r_out_last;
  assign bus.out_StreamID  = r_out_stream;
  assign bus.out_ChunkID   = r_out_chunk;
  assign bus.out_ChannelID = r_out_channel;
  assign bus.out_State     = r_out_state;
  assign bus.cmd_ready     = (r_state == S_IDLE) && !rst;
  assign bus.resp_valid    = r_resp_valid;
  assign bus.resp_rdata    = r_resp_rdata;
  assign bus.resp_timeout  = r_resp_timeout;
  assign bus.busy          = (r_state != S_IDLE);
endmodule

// File: tb/tb_ctrl_packet_injector.sv
// Scenario bench for ctrl_packet_injector: directed timing checks plus a randomized ordering scoreboard.
module tb_ctrl_packet_injector;
  localparam int DW = 512, SN = 16, CN = 32, HN = 1024, STW = 32, TO = 16;
  localparam int SW = $clog2(SN), CW = $clog2(CN), HW = $clog2(HN);

  typedef struct packed {
    logic [DW-1:0]  d;
    logic [1:0]     t;
    logic           l;
    logic [SW-1:0]  s;
    logic [CW-1:0]  c;
    logic [HW-1:0]  h;
    logic [STW-1:0] st;
  } beat_t;

  typedef struct packed {
    logic [HW-1:0] hop;
    logic [31:0]   addr;
    logic [31:0]   wd;
  } cmd_t;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  ctrl_packet_injector_if #(.DATA_WIDTH(DW), .STREAM_ID_NUM(SN), .CHUNK_ID_NUM(CN),
                            .CHANNEL_ID_NUM(HN), .STATE_WIDTH(STW)) bus ();

  ctrl_packet_injector #(.DATA_WIDTH(DW), .STREAM_ID_NUM(SN), .CHUNK_ID_NUM(CN),
                         .CHANNEL_ID_NUM(HN), .STATE_WIDTH(STW), .TIMEOUT_CYCLES(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] r;
    for (int i = 0; i < DW/32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Expected control beat straight from the packet format rules.
  function automatic beat_t ctrl_beat(input logic wr, input logic [HW-1:0] hop,
                                      input logic [31:0] addr, input logic [31:0] wd);
    beat_t b;
    b.d  = wr ? {(DW/32){wd}} : '0;
    b.t  = 2'b10;
    b.l  = 1'b1;
    b.s  = '0;
    b.c  = wr ? 5'b10001 : 5'b10000;
    b.h  = hop;
    b.st = addr;
    return b;
  endfunction

  function automatic beat_t out_beat();
    beat_t b;
    b.d = bus.out_Data; b.t = bus.out_Type; b.l = bus.out_Last; b.s = bus.out_StreamID;
    b.c = bus.out_ChunkID; b.h = bus.out_ChannelID; b.st = bus.out_State;
    return b;
  endfunction

  task automatic idle_in();
    bus.in_Data = '0; bus.in_Type = 2'b00; bus.in_Last = 1'b0; bus.in_StreamID = '0;
    bus.in_ChunkID = '0; bus.in_ChannelID = '0; bus.in_State = '0;
    bus.ret_Data = '0; bus.ret_Type = 2'b00; bus.ret_ChunkID = '0; bus.ret_State = '0;
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_hop = '0; bus.cmd_addr = '0; bus.cmd_wdata = '0;
  endtask

  task automatic drive_cmd(input logic wr, input logic [HW-1:0] hop, input logic [31:0] addr, input logic [31:0] wd);
    bus.cmd_valid = 1'b1; bus.cmd_write = wr; bus.cmd_hop = hop; bus.cmd_addr = addr; bus.cmd_wdata = wd;
  endtask

  task automatic drive_ret(input logic [1:0] t, input logic [CW-1:0] c, input logic [31:0] st, input logic [31:0] d);
    bus.ret_Type = t; bus.ret_ChunkID = c; bus.ret_State = st;
    bus.ret_Data = rand_data();
    bus.ret_Data[31:0] = d;
  endtask

  task automatic test_reset();
    idle_in();
    rst = 1'b1;
    bus.in_Type = 2'b01; bus.in_Data = rand_data(); bus.cmd_valid = 1'b1;
    tick(); tick();
    n_vec++; if (bus.out_Type !== 2'b00) begin n_err++; $display("FAIL reset_out_type got=%0h exp=0", bus.out_Type); end
    n_vec++; if (bus.out_Data !== '0) begin n_err++; $display("FAIL reset_out_data got=%0h exp=0", bus.out_Data[63:0]); end
    n_vec++; if ({bus.resp_valid, bus.resp_timeout, bus.resp_rdata} !== 34'd0) begin
      n_err++; $display("FAIL reset_resp got v=%b t=%b d=%h exp all 0", bus.resp_valid, bus.resp_timeout, bus.resp_rdata); end
    n_vec++; if ({bus.busy, bus.cmd_ready} !== 2'b00) begin
      n_err++; $display("FAIL reset_busy_ready got busy=%b ready=%b exp 0 0", bus.busy, bus.cmd_ready); end
    idle_in();
    rst = 1'b0;
    #1;
    n_vec++; if (bus.cmd_ready !== 1'b1) begin n_err++; $display("FAIL reset_release_ready got=%b exp=1", bus.cmd_ready); end
  endtask

  task automatic test_write();
    beat_t exp_b, got_b;
    bit    bad = 0;
    drive_cmd(1'b1, HW'(3), 32'h10, 32'hA5A5_0001);
    n_vec++; if (bus.cmd_ready !== 1'b1) begin n_err++; $display("FAIL write_ready_idle got=%b exp=1", bus.cmd_ready); end
    tick();
    bus.cmd_valid = 1'b0;
    n_vec++; if ({bus.busy, bus.cmd_ready, bus.out_Type} !== 4'b1000) begin
      n_err++; $display("FAIL write_pending got busy=%b ready=%b type=%0h exp 1 0 0", bus.busy, bus.cmd_ready, bus.out_Type); end
    tick();
    exp_b = ctrl_beat(1'b1, HW'(3), 32'h10, 32'hA5A5_0001);
    got_b = out_beat();
    n_vec++; if (got_b !== exp_b) begin n_err++;
      $display("FAIL write_inject got t=%0h c=%b h=%0d st=%h l=%b d=%h exp t=2 c=10001 h=3 st=10 l=1 d=a5a50001..",
               got_b.t, got_b.c, got_b.h, got_b.st, got_b.l, got_b.d[63:0]); end
    n_vec++; if ({bus.cmd_ready, bus.busy} !== 2'b10) begin
      n_err++; $display("FAIL write_back_idle got ready=%b busy=%b exp 1 0", bus.cmd_ready, bus.busy); end
    for (int k = 0; k < 4; k++) begin
      if (bus.resp_valid !== 1'b0) bad = 1;
      tick();
    end
    n_vec++; if (bad) begin n_err++; $display("FAIL write_no_resp got resp_valid=1 exp 0"); end
  endtask

  task automatic test_gap();
    beat_t exp_b[4];
    beat_t got_b;
    logic [31:0] wd = $urandom;
    for (int i = 0; i < 4; i++) begin
      exp_b[i] = '{d: rand_data(), t: 2'b01, l: (i == 3), s: SW'(i + 1), c: CW'(i), h: HW'($urandom), st: $urandom};
    end
    for (int i = 0; i < 4; i++) begin
      bus.in_Data = exp_b[i].d; bus.in_Type = exp_b[i].t; bus.in_Last = exp_b[i].l; bus.in_StreamID = exp_b[i].s;
      bus.in_ChunkID = exp_b[i].c; bus.in_ChannelID = exp_b[i].h; bus.in_State = exp_b[i].st;
      if (i == 0) drive_cmd(1'b1, HW'(5), 32'h44, wd);
      tick();
      bus.cmd_valid = 1'b0;
      got_b = out_beat();
      n_vec++; if (got_b !== exp_b[i]) begin n_err++;
        $display("FAIL gap_beat%0d got t=%0h l=%b st=%h d=%h exp t=1 l=%b st=%h d=%h", i + 1,
                 got_b.t, got_b.l, got_b.st, got_b.d[63:0], exp_b[i].l, exp_b[i].st, exp_b[i].d[63:0]); end
    end
    idle_in();
    tick();
    got_b = out_beat();
    n_vec++; if (got_b !== ctrl_beat(1'b1, HW'(5), 32'h44, wd)) begin n_err++;
      $display("FAIL gap_inject got t=%0h c=%b h=%0d st=%h exp t=2 c=10001 h=5 st=44", got_b.t, got_b.c, got_b.h, got_b.st); end
    tick();
  endtask

  task automatic test_read_hit();
    beat_t got_b;
    bit    early = 0;
    drive_cmd(1'b0, HW'(0), 32'h20, $urandom);
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    got_b = out_beat();
    n_vec++; if (got_b !== ctrl_beat(1'b0, HW'(0), 32'h20, 32'd0)) begin n_err++;
      $display("FAIL read_inject got t=%0h c=%b h=%0d st=%h d=%h exp t=2 c=10000 h=0 st=20 d=0",
               got_b.t, got_b.c, got_b.h, got_b.st, got_b.d[63:0]); end
    for (int k = 0; k < 5; k++) begin
      tick();
      if (bus.resp_valid !== 1'b0) early = 1;
    end
    drive_ret(2'b10, 5'b00001, 32'h20, 32'h1234_5678);
    tick();
    idle_in();
    n_vec++; if (early) begin n_err++; $display("FAIL read_early_resp got resp_valid=1 before return exp 0"); end
    n_vec++; if ({bus.resp_valid, bus.resp_timeout, bus.resp_rdata} !== {1'b1, 1'b0, 32'h1234_5678}) begin n_err++;
      $display("FAIL read_hit got v=%b t=%b d=%h exp v=1 t=0 d=12345678", bus.resp_valid, bus.resp_timeout, bus.resp_rdata); end
    tick();
    n_vec++; if ({bus.resp_valid, bus.busy, bus.cmd_ready, bus.resp_rdata} !== {3'b001, 32'h1234_5678}) begin n_err++;
      $display("FAIL read_after got v=%b busy=%b ready=%b d=%h exp 0 0 1 12345678",
               bus.resp_valid, bus.busy, bus.cmd_ready, bus.resp_rdata); end
  endtask

  task automatic test_timeout();
    bit early = 0;
    drive_cmd(1'b0, HW'(9), 32'h20, 32'd0);
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    for (int k = 1; k <= TO; k++) begin
      case (k % 4)
        0: drive_ret(2'b10, 5'b00001, 32'h24, 32'hDEAD_0000 + k);
        1: drive_ret(2'b01, 5'b00001, 32'h20, 32'hDEAD_1000 + k);
        2: drive_ret(2'b10, 5'b10001, 32'h20, 32'hDEAD_2000 + k);
        default: drive_ret(2'b10, 5'b00010, 32'h20, 32'hDEAD_3000 + k);
      endcase
      tick();
      if (k < TO && bus.resp_valid !== 1'b0) early = 1;
    end
    idle_in();
    n_vec++; if (early) begin n_err++; $display("FAIL timeout_early got resp_valid before %0d cycles exp none", TO); end
    n_vec++; if ({bus.resp_valid, bus.resp_timeout, bus.resp_rdata} !== {1'b1, 1'b1, 32'd0}) begin n_err++;
      $display("FAIL timeout_resp got v=%b t=%b d=%h exp v=1 t=1 d=0", bus.resp_valid, bus.resp_timeout, bus.resp_rdata); end
    tick();
    n_vec++; if ({bus.resp_valid, bus.resp_timeout, bus.busy} !== 3'b010) begin n_err++;
      $display("FAIL timeout_after got v=%b t=%b busy=%b exp 0 1 0", bus.resp_valid, bus.resp_timeout, bus.busy); end
  endtask

  task automatic test_simultaneous();
    logic [31:0] addr = $urandom;
    logic [31:0] d    = $urandom;
    bit early = 0;
    drive_cmd(1'b0, HW'(2), addr, 32'd0);
    tick();
    bus.cmd_valid = 1'b0;
    drive_ret(2'b10, 5'b00001, addr, ~d);
    tick();
    idle_in();
    for (int k = 1; k <= TO; k++) begin
      if (k == TO) drive_ret(2'b10, 5'b00001, addr, d);
      tick();
      idle_in();
      if (k < TO && bus.resp_valid !== 1'b0) early = 1;
    end
    n_vec++; if (early) begin n_err++; $display("FAIL simul_early got resp_valid before last timer cycle exp none"); end
    n_vec++; if ({bus.resp_valid, bus.resp_timeout, bus.resp_rdata} !== {1'b1, 1'b0, d}) begin n_err++;
      $display("FAIL simul_match_wins got v=%b t=%b d=%h exp v=1 t=0 d=%h", bus.resp_valid, bus.resp_timeout, bus.resp_rdata, d); end
    tick();
  endtask

  task automatic test_reset_mid_read();
    logic [31:0] addr = $urandom;
    bit bad_resp = 0, bad_out = 0;
    drive_cmd(1'b0, HW'(1), addr, 32'd0);
    tick();
    bus.cmd_valid = 1'b0;
    tick(); tick();
    bus.in_Type = 2'b01; bus.in_Last = 1'b1; bus.in_Data = rand_data(); bus.in_State = 32'hFFFF_FFFF;
    tick();
    idle_in();
    #2 rst = 1'b1;
    #1;
    n_vec++; if ({bus.out_Type, bus.out_State, bus.out_Data[31:0]} !== '0) begin n_err++;
      $display("FAIL rst_mid_out got t=%0h st=%h d=%h exp 0", bus.out_Type, bus.out_State, bus.out_Data[31:0]); end
    n_vec++; if ({bus.busy, bus.cmd_ready, bus.resp_rdata, bus.resp_timeout} !== '0) begin n_err++;
      $display("FAIL rst_mid_state got busy=%b ready=%b rdata=%h to=%b exp 0", bus.busy, bus.cmd_ready, bus.resp_rdata, bus.resp_timeout); end
    tick();
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      drive_ret(2'b10, 5'b00001, addr, $urandom);
      tick();
      if (bus.resp_valid !== 1'b0) bad_resp = 1;
      if (bus.out_Type !== 2'b00) bad_out = 1;
    end
    idle_in();
    n_vec++; if (bad_resp) begin n_err++; $display("FAIL rst_mid_resp got resp_valid=1 after abort exp 0"); end
    n_vec++; if (bad_out) begin n_err++; $display("FAIL rst_mid_inject got out_Type!=0 after abort exp 0"); end
  endtask

  // Random traffic: upstream beats must come out in order and intact; writes appear only between packets.
  task automatic test_random();
    beat_t bq[$];
    cmd_t  cq[$];
    beat_t b, g;
    cmd_t  c;
    int    rem = 0;
    bit    out_open = 0;
    idle_in();
    for (int cyc = 0; cyc < 700; cyc++) begin
      if (rem == 0 && cyc < 600 && $urandom_range(0, 9) < 6) rem = $urandom_range(1, 4);
      if (rem > 0) begin
        b = '{d: rand_data(), t: 2'($urandom_range(1, 3)), l: (rem == 1), s: SW'($urandom),
              c: {1'b0, 4'($urandom)}, h: HW'($urandom), st: $urandom};
        bus.in_Data = b.d; bus.in_Type = b.t; bus.in_Last = b.l; bus.in_StreamID = b.s;
        bus.in_ChunkID = b.c; bus.in_ChannelID = b.h; bus.in_State = b.st;
        bq.push_back(b);
        rem--;
      end else begin
        bus.in_Type = 2'b00; bus.in_Last = 1'b0;
      end
      if (cyc < 600 && bus.cmd_ready === 1'b1 && $urandom_range(0, 5) == 0) begin
        c = '{hop: HW'($urandom), addr: $urandom, wd: $urandom};
        drive_cmd(1'b1, c.hop, c.addr, c.wd);
        cq.push_back(c);
      end else begin
        bus.cmd_valid = 1'b0;
      end
      tick();
      g = out_beat();
      if (g.t != 2'b00) begin
        n_vec++;
        if (g.t == 2'b10 && g.c[CW-1]) begin
          if (cq.size() == 0 || out_open || g !== ctrl_beat(1'b1, cq[0].hop, cq[0].addr, cq[0].wd)) begin
            n_err++;
            $display("FAIL rand_ctrl cyc=%0d got h=%0d st=%h d=%h open=%b pending=%0d", cyc, g.h, g.st, g.d[31:0], out_open, cq.size());
          end
          if (cq.size() > 0) void'(cq.pop_front());
        end else begin
          if (bq.size() == 0 || g !== bq[0]) begin
            n_err++;
            $display("FAIL rand_beat cyc=%0d got t=%0h st=%h d=%h exp st=%h d=%h", cyc, g.t, g.st, g.d[31:0],
                     (bq.size() > 0) ? bq[0].st : 32'd0, (bq.size() > 0) ? bq[0].d[31:0] : 32'd0);
          end
          if (bq.size() > 0) void'(bq.pop_front());
          out_open = !g.l;
        end
      end
    end
    idle_in();
    n_vec++; if (bq.size() != 0 || cq.size() != 0) begin n_err++;
      $display("FAIL rand_drain got beats_left=%0d cmds_left=%0d exp 0 0", bq.size(), cq.size()); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_gap();
    test_read_hit();
    test_timeout();
    test_simultaneous();
    test_reset_mid_read();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/ctrl_packet_injector.md
Name: ctrl_packet_injector

Overview:
Host-side configuration sequencer that owns one forward data link into a module chain. It passes the upstream forward stream through with one register stage. It injects single-beat relative-addressed control packets (CP_R_CTRL_WRITE_32b / CP_R_CTRL_READ_REQUEST_32b) only into idle gaps between packets. For reads it waits for the matching absolute CP_A_CTRL_READ_RESPONSE_32b on the return link, with a timeout.

Parameters:
DATA_WIDTH, 512, forward data width (multiple of 32)
STREAM_ID_NUM, 16, virtual streams; STREAM_ID_WIDTH = $clog2
CHUNK_ID_NUM, 32, chunk ids; CHUNK_ID_WIDTH = $clog2
CHANNEL_ID_NUM, 1024, channels; CHANNEL_ID_WIDTH = $clog2
STATE_WIDTH, 32, state/address field width
TIMEOUT_CYCLES, 1024, read-response timeout in clk cycles (>=2)
CP_R_CTRL_READ_REQUEST_32b, 0, relative opcode
CP_R_CTRL_WRITE_32b, 1, relative opcode
CP_A_CTRL_READ_RESPONSE_32b, 1, absolute opcode

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
in_Data/in_Type/in_Last/in_StreamID/in_ChunkID/in_ChannelID/in_State  in  DATA_WIDTH/2/1/STREAM_ID_WIDTH/CHUNK_ID_WIDTH/CHANNEL_ID_WIDTH/STATE_WIDTH  upstream forward stream
out_Data/out_Type/out_Last/out_StreamID/out_ChunkID/out_ChannelID/out_State  out  same widths  registered forward stream to chain
ret_Data  in  DATA_WIDTH  return link data
ret_Type  in  2  return link type
ret_ChunkID  in  CHUNK_ID_WIDTH  return link chunk id
ret_State  in  STATE_WIDTH  return link state (address)
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when valid&ready
cmd_write  in  1  1=write, 0=read
cmd_hop  in  CHANNEL_ID_WIDTH  relative target (0 = first module)
cmd_addr  in  STATE_WIDTH  register address
cmd_wdata  in  32  write value
resp_valid  out  1  one-cycle read completion pulse
resp_rdata  out  32  read data
resp_timeout  out  1  qualifies resp_valid: 1 = timed out
busy  out  1  state != IDLE

Behaviour:
- Type encoding: bit1 = control valid, bit0 = data valid, 0 = idle. ChunkID MSB = 1 means relative addressing; ChunkID[CHUNK_ID_WIDTH-2:0] = opcode.
- Reset (async, rst=1): all out_* = 0 (out_Type = 0), resp_valid = 0, resp_rdata = 0, resp_timeout = 0, state = IDLE, pkt_open = 0, timer = 0. cmd_ready = 0 while rst=1.
- Passthrough: every cycle not injecting, out_* <= in_* (latency 1, no modification).
- pkt_open register: set on a valid input beat (in_Type != 0) with in_Last = 0; cleared on a valid beat with in_Last = 1.
- gap = (in_Type == 0) && !pkt_open. Injection only in a gap cycle, so upstream beats are never dropped or split.
- FSM:
  - IDLE: cmd_ready = 1. On cmd_valid, latch cmd_* -> PENDING.
  - PENDING: on first gap cycle, register the injected packet:
    - out_Type = 2'b10, out_Last = 1, out_StreamID = 0
    - out_ChunkID = {1'b1, opcode}
    - out_ChannelID = cmd_hop, out_State = cmd_addr
    - out_Data = cmd_wdata replicated into every 32-bit field for a write, 0 for a read
    - Write -> IDLE. Read -> WAIT_RESP with timer = 0.
  - WAIT_RESP: timer increments every cycle. Match = ret_Type[1] && ret_ChunkID MSB == 0 && opcode == CP_A_CTRL_READ_RESPONSE_32b && ret_State == latched addr.
    - On match: resp_valid = 1, resp_rdata = ret_Data[31:0], resp_timeout = 0 -> IDLE.
    - Else, when timer == TIMEOUT_CYCLES-1: resp_valid = 1, resp_rdata = 0, resp_timeout = 1 -> IDLE.
    - Match and timeout in the same cycle: the match wins.
    - Non-matching return traffic is ignored.
- Returns to IDLE occur one cycle after the injection/response. cmd_ready re-asserts that cycle. Writes produce no resp_valid.
- resp_* outputs are registered. resp_valid is high for exactly one cycle; resp_rdata and resp_timeout hold until the next response.
- Return beats arriving in the injection cycle are not matched. Matching starts the cycle after the request is on out_*.
- rst mid-operation aborts the latched command; no injection and no response follow.
- Continuous upstream traffic with no gap stalls PENDING indefinitely. This is permitted, and busy stays 1.

Test Plan:
- Write, idle input: cmd write hop=3 addr=0x10 wdata=0xA5A5_0001. Two cycles later out_Type=2, out_ChunkID=5'b10001, out_ChannelID=3, out_State=0x10, all 16 data words=0xA5A50001, out_Last=1. cmd_ready returns to 1 and no resp_valid.
- Gap protection: 4-beat data packet (Last on beat 4) with a write issued during beat 1. Output shows beats 1-4 unmodified at latency 1, and the control packet appears on the cycle after beat 4.
- Read hit: read hop=0 addr=0x20; return link at +7 cycles carries Type=2, ChunkID=5'b00001, State=0x20, Data[31:0]=0x1234_5678. resp_valid pulses once with rdata=0x12345678, timeout=0.
- Read mismatch then timeout: TIMEOUT_CYCLES=16; return carries State=0x24 only. resp_valid with resp_timeout=1, rdata=0 exactly 16 cycles after injection.
- Simultaneous: a matching response lands on cycle TIMEOUT_CYCLES-1 -> resp_timeout=0 with data returned.
- Reset mid-read: assert rst in WAIT_RESP. Outputs immediately 0 and busy=0; a later matching response produces no resp_valid.
